// File: rtl/frame_pkg.sv
// Shared frame definitions for the serial transmit scheduler and the receive-side aligner.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    HEADER,
    PAYLOAD
  } frame_state_t;

  localparam int DEF_ZERO_LEN    = 160;
  localparam int DEF_SYNC_LEN    = 8;
  localparam int DEF_PAYLOAD_LEN = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Header width: max(1, clog2(n)).
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_tx_sched_rr_arbiter.sv
// Round-robin requester pick; the pointer moves past the granted source when a frame ends.
module rr_arbiter
  import frame_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    grant_idx,
  input  logic               advance,
  output logic [NUM_SRC-1:0] pick,
  output logic [ID_W-1:0]    pick_idx
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_SRC-1:0] hi;
  logic [NUM_SRC-1:0] cand;
  logic               found;

  // Requesters at or above the pointer win; otherwise wrap to the lowest requester.
  always_comb begin
    hi = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      hi[s] = req[s] && (s >= int'(rr_ptr));
    end
    cand     = (|hi) ? hi : req;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (cand[s] && !found) begin
        found    = 1'b1;
        pick[s]  = 1'b1;
        pick_idx = ID_W'(s);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/frame_tx_sched.sv
// Frame scheduler: grants one source per frame and serialises preamble, sync, header and payload.
module frame_tx_sched
  import frame_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int ZERO_LEN    = DEF_ZERO_LEN,
  parameter int SYNC_LEN    = DEF_SYNC_LEN,
  parameter int PAYLOAD_LEN = DEF_PAYLOAD_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] src_bit,
  input  logic [NUM_SRC-1:0] src_valid,
  output logic [NUM_SRC-1:0] src_ready,
  output logic [NUM_SRC-1:0] grant,
  output logic               data_out,
  output logic               frame_active,
  output logic               frame_done,
  output logic               underrun
);

  localparam int ID_W    = id_width(NUM_SRC);
  localparam int MAX_LEN = max3(ZERO_LEN, SYNC_LEN, PAYLOAD_LEN);
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  frame_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    g_idx;
  logic [ID_W-1:0]    hdr_sr;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_SRC-1:0] pick;
  logic               start;
  logic               last_bit;
  logic               cur_bit;
  logic               cur_valid;

  // The frame_done cycle is forced idle so back-to-back frames keep one zero bit between them.
  assign start     = enable && (|req) && !frame_done;
  assign last_bit  = (state == PAYLOAD) && (cnt == CNT_W'(PAYLOAD_LEN - 1));
  assign cur_bit   = |(src_bit & grant);
  assign cur_valid = |(src_valid & grant);
  assign src_ready = (state == PAYLOAD) ? grant : '0;

  rr_arbiter #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant_idx(g_idx),
    .advance  (last_bit),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      grant        <= '0;
      g_idx        <= '0;
      hdr_sr       <= '0;
      data_out     <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
      frame_active <= 1'b1;
      cnt          <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          data_out     <= 1'b0;
          cnt          <= '0;
          frame_active <= start;
          if (start) begin
            grant  <= pick;
            g_idx  <= pick_idx;
            hdr_sr <= pick_idx;
            state  <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          // The arbitration edge already loaded preamble bit 0, so this state is one bit short.
          data_out <= 1'b0;
          if (cnt == CNT_W'(ZERO_LEN - 2)) begin
            state <= SYNC;
            cnt   <= '0;
          end
        end
        SYNC: begin
          data_out <= 1'b1;
          if (cnt == CNT_W'(SYNC_LEN - 1)) begin
            state <= HEADER;
            cnt   <= '0;
          end
        end
        HEADER: begin
          data_out <= hdr_sr[ID_W-1];
          hdr_sr   <= hdr_sr << 1;
          if (cnt == CNT_W'(ID_W - 1)) begin
            state <= PAYLOAD;
            cnt   <= '0;
          end
        end
        PAYLOAD: begin
          data_out <= cur_valid & cur_bit;
          underrun <= !cur_valid;
          if (last_bit) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b1;
            grant      <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
